stage_memory: RTL

// - Pipeline MEM stage: consumes the EX->MEM register (mem_*) and drives one word-wide data-memory bus.
// - Selects the write-back value and registers it into the MEM->WB register (wb_*).
// - Raises mem_stall to the hazard unit while a bus transaction is outstanding.
// - wb_result from this stage is the forwarding source fed back to EX.

---
 rtl/stage_memory.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/stage_memory.sv
// Pipeline MEM stage: drives the data-memory bus, registers the MEM->WB value.
// Latency: 1 cycle to wb_* when no access; loads stall until rvalid, stores until gnt.
// Backpressure: mem_stall holds upstream while a bus transaction is outstanding.
// Optional MEM_ALIGN_CHECK_EN: misaligned ld/st are suppressed and flagged on wb_misaligned.
module stage_memory #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_clear,
    input  logic                 mem_reg_write,
    input  logic                 mem_mem_write,
    input  logic [1:0]           mem_result_src,
    input  logic [XLEN-1:0]      mem_alu_result,
    input  logic [XLEN-1:0]      mem_write_data,
    input  logic [XLEN-1:0]      mem_pc_plus_4,
    input  logic [XLEN-1:0]      mem_imm_ext,
    input  logic [RF_ADDR_W-1:0] mem_rd,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvalid,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 mem_stall,
    output logic                 wb_reg_write,
    output logic [RF_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]      wb_result,
    output logic                 wb_misaligned
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_GNT  = 2'd1,
        S_WAIT_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic is_load;
    logic is_store;
    logic misaligned;
    logic access;
    logic req;
    logic pending;
    logic complete;
    logic [XLEN-1:0] result_sel;

    logic                 wb_reg_write_q;
    logic [RF_ADDR_W-1:0] wb_rd_q;
    logic [XLEN-1:0]      wb_result_q;

    // Classify the instruction in MEM and decide whether it needs the bus.
    always_comb begin
        is_load  = mem_reg_write & (mem_result_src == 2'b01) & ~mem_mem_write;
        is_store = mem_mem_write;
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = (is_load | is_store) & (mem_alu_result[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        access = (is_load | is_store) & ~misaligned;
    end

    // Bus FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, bus request and completion; reset forces the bus quiet at once.
    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        pending  = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE, S_WAIT_GNT: begin
                if (access) begin
                    pending = 1'b1;
                    req     = 1'b1;
                    if (dmem_gnt) begin
                        if (is_store) begin
                            complete = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            state_d  = S_WAIT_RESP;
                        end
                    end else begin
                        state_d = S_WAIT_GNT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_RESP: begin
                // Load data only counts here; a load never completes in its request cycle.
                pending = 1'b1;
                if (dmem_rvalid) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (reset) begin
            req      = 1'b0;
            pending  = 1'b0;
            complete = 1'b0;
            state_d  = S_IDLE;
        end
    end

    // Bus outputs are combinational from the held mem_* inputs.
    always_comb begin
        dmem_req   = req;
        dmem_we    = ~reset & is_store;
        dmem_addr  = reset ? '0 : mem_alu_result;
        dmem_wdata = reset ? '0 : mem_write_data;
        mem_stall  = pending & ~complete;
    end

    // Write-back value selection.
    always_comb begin
        result_sel = mem_alu_result;
        case (mem_result_src)
            2'b00:   result_sel = mem_alu_result;
            2'b01:   result_sel = dmem_rdata;
            2'b10:   result_sel = mem_pc_plus_4;
            2'b11:   result_sel = mem_imm_ext;
            default: result_sel = mem_alu_result;
        endcase
    end

    // MEM->WB register: stall inserts a bubble, stores and misaligned accesses never write rd.
    always_ff @(posedge clk) begin
        if (reset || wb_clear) begin
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_result_q    <= '0;
        end else if (mem_stall) begin
            wb_reg_write_q <= 1'b0;
        end else begin
            wb_reg_write_q <= mem_reg_write & ~mem_mem_write & ~misaligned;
            wb_rd_q        <= mem_rd;
            wb_result_q    <= result_sel;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic wb_misaligned_q;

    // Misaligned flag travels with the instruction into WB.
    always_ff @(posedge clk) begin
        if (reset || wb_clear) begin
            wb_misaligned_q <= 1'b0;
        end else if (!mem_stall) begin
            wb_misaligned_q <= misaligned;
        end
    end

    assign wb_misaligned = wb_misaligned_q;
`else
    assign wb_misaligned = 1'b0;
`endif

    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_result    = wb_result_q;

endmodule
